// File: rtl/servo_pwm.sv
// servo_pwm: frame-based servo/ESC pulse generator timed by a 1 us tick strobe.
// Define SERVO_PWM_FAILSAFE_EN to fall back to DEFAULT after TIMEOUT_FRAMES frames without an update.
module servo_pwm #(
    parameter logic [9:0]  DEFAULT        = 10'd512,
    parameter logic [10:0] OFFSET         = 11'd988,
    parameter logic [14:0] PERIOD_US      = 15'd20000,
    parameter logic [7:0]  TIMEOUT_FRAMES = 8'd25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1us,
    input  logic       en,
    input  logic [9:0] val,
    input  logic       val_valid,
    output logic       pwm,
    output logic       frame_start,
    output logic [9:0] active_val,
    output logic       failsafe
);
    typedef enum logic [1:0] {DISABLED, HIGH, LOW} state_t;
    state_t      state_q, state_d;
    logic [14:0] cnt_q, cnt_d, cnt_inc;
    logic [10:0] width_q, width_d;
    logic [9:0]  shadow_q, shadow_d, act_q, act_d, load_val;
    logic        pwm_q, pwm_d, fs_q, fs_d, stop_q, stop_d, load;
`ifdef SERVO_PWM_FAILSAFE_EN
    logic [7:0]  to_q, to_d;
    logic        fail_q, fail_d;
`endif
    assign cnt_inc  = cnt_q + 15'd1;
    assign load_val = val_valid ? val : shadow_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        act_d    = act_q;
        shadow_d = load_val;
        pwm_d    = pwm_q;
        fs_d     = 1'b0;
        load     = 1'b0;
        // a drop of en is remembered so a pulse in progress always ends in DISABLED
        stop_d   = (state_q == DISABLED) ? 1'b0 : (stop_q | ~en);
        case (state_q)
            DISABLED: load = tick_1us & en;
            HIGH: if (tick_1us) begin
                cnt_d = cnt_inc;
                if (cnt_inc == {4'd0, width_q}) begin
                    pwm_d   = 1'b0;
                    state_d = stop_d ? DISABLED : LOW;
                end
            end
            LOW: if (stop_d) state_d = DISABLED;
                 else if (tick_1us) begin
                     cnt_d = cnt_inc;
                     load  = (cnt_inc == PERIOD_US);
                 end
            default: state_d = DISABLED;
        endcase
        if (load) begin
            state_d = HIGH;
            cnt_d   = '0;
            act_d   = load_val;
            width_d = OFFSET + {1'b0, load_val};
            pwm_d   = 1'b1;
            fs_d    = 1'b1;
        end
`ifdef SERVO_PWM_FAILSAFE_EN
        to_d   = to_q;
        fail_d = fail_q;
        if (val_valid) begin
            to_d   = '0;
            fail_d = 1'b0;
        end else if (load && to_q != TIMEOUT_FRAMES) begin
            to_d = to_q + 8'd1;
            if (to_d == TIMEOUT_FRAMES) begin
                shadow_d = DEFAULT;
                fail_d   = 1'b1;
            end
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DISABLED;
            cnt_q    <= '0;
            width_q  <= '0;
            act_q    <= DEFAULT;
            shadow_q <= DEFAULT;
            pwm_q    <= 1'b0;
            fs_q     <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            act_q    <= act_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
            fs_q     <= fs_d;
            stop_q   <= stop_d;
        end
    end
`ifdef SERVO_PWM_FAILSAFE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q   <= '0;
            fail_q <= 1'b0;
        end else begin
            to_q   <= to_d;
            fail_q <= fail_d;
        end
    end
    assign failsafe = fail_q;
`else
    assign failsafe = 1'b0;
`endif
    assign pwm         = pwm_q;
    assign frame_start = fs_q;
    assign active_val  = act_q;
endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: stimulus queues the expected value/width/failsafe of each frame;
// a negedge monitor consumes one entry per frame_start and measures pulse width and frame length in ticks.
`timescale 1ns/1ps
module tb_servo_pwm;
    localparam int PER = 2500;
    typedef struct {logic [9:0] av; int w; logic fs; logic cp;} exp_t;
    logic       clk = 1'b0, rst = 1'b1, tick_1us = 1'b1, en = 1'b0, val_valid = 1'b0;
    logic [9:0] val = '0;
    logic       pwm, frame_start, failsafe;
    logic [9:0] active_val;
    exp_t       sb[$];
    exp_t       e;
    int         checks = 0, errors = 0;
    int         fr_cnt = 0, hi_cnt = 0, exp_w = 0;
    bit         in_p = 1'b0;

    servo_pwm #(.PERIOD_US(15'd2500), .TIMEOUT_FRAMES(8'd4)) dut (
        .clk(clk), .rst(rst), .tick_1us(tick_1us), .en(en), .val(val), .val_valid(val_valid),
        .pwm(pwm), .frame_start(frame_start), .active_val(active_val), .failsafe(failsafe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [9:0] v);
        val = v;
        val_valid = 1'b1;
        step(1);
        val_valid = 1'b0;
    endtask

    task automatic push(input logic [9:0] av, input int w, input logic fs, input logic cp);
        exp_t x;
        x = '{av, w, fs, cp};
        sb.push_back(x);
    endtask

    task automatic wait_frame(input int lim);
        int n = 0;
        @(negedge clk);
        while (!frame_start && n < lim) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!frame_start) begin
            errors++;
            $display("FAIL frame_wait: no frame_start within %0d clks", lim);
        end
    endtask

    // tick_1us seen at a negedge is the value the next rising edge will sample
    always @(negedge clk) begin
        if (rst) begin
            in_p = 1'b0;
        end else begin
            if (frame_start) begin
                in_p = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_frame_start", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("frame_av", active_val, e.av);
                    chk("frame_failsafe", failsafe, e.fs);
                    if (e.cp) chk("frame_period", fr_cnt, PER);
                    exp_w = e.w;
                    in_p  = 1'b1;
                end
                fr_cnt = 0;
                hi_cnt = 0;
            end
            if (in_p && !pwm) begin
                chk("pulse_width", hi_cnt, exp_w);
                in_p = 1'b0;
            end
            if (tick_1us) begin
                fr_cnt++;
                if (pwm) hi_cnt++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst_pwm", pwm, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_active_val", active_val, 512);
        chk("rst_failsafe", failsafe, 0);
        rst = 1'b0;
        step(3);
        chk("disabled_pwm", pwm, 0);
        // default value frames
        push(512, 1500, 0, 0);
        push(512, 1500, 0, 1);
        en = 1'b1;
        wait_frame(10);
        wait_frame(PER + 10);
        // extremes of the command range
        step(10); upd(10'd0); push(0, 988, 0, 1);
        wait_frame(PER + 10);
        step(10); upd(10'd1023); push(1023, 2011, 0, 1);
        wait_frame(PER + 10);
        // mid-frame update waits for the next frame
        step(699); upd(10'd300); push(300, 1288, 0, 1);
        step(5);
        chk("midframe_av", active_val, 1023);
        wait_frame(PER + 10);
        // update on the load edge is used immediately
        push(100, 1088, 0, 1);
        step(PER - 1);
        val = 10'd100; val_valid = 1'b1;
        step(1);
        val_valid = 1'b0;
        chk("bypass_frame_start", frame_start, 1);
        chk("bypass_av", active_val, 100);
        // cycles without tick hold all state
        push(512, 1500, 0, 1);
        step(10); tick_1us = 1'b0;
        step(50);
        chk("hold_pwm", pwm, 1);
        chk("hold_av", active_val, 100);
        tick_1us = 1'b1;
        step(100); upd(10'd512);
        wait_frame(PER + 10);
        // en dropped mid-pulse: full pulse then idle
        step(99); en = 1'b0;
        step(1500);
        chk("en_off_pwm_a", pwm, 0);
        step(1500);
        chk("en_off_pwm_b", pwm, 0);
        push(512, 1500, 0, 0);
        en = 1'b1;
        step(1);
        chk("reenable_frame_start", frame_start, 1);
        // en glitch during the pulse: pulse completes, DISABLED, then reload on next tick
        step(100); en = 1'b0;
        step(5); en = 1'b1;
        step(100); upd(10'd512);
        push(512, 1500, 0, 0);
        wait_frame(1400);
        // update timeout
        step(10); upd(10'd1000);
        for (int i = 0; i < 5; i++) begin
`ifdef SERVO_PWM_FAILSAFE_EN
            if (i < 3) push(1000, 1988, 0, 1);
            else if (i == 3) push(1000, 1988, 1, 1);
            else push(512, 1500, 1, 1);
`else
            push(1000, 1988, 0, 1);
`endif
        end
        repeat (5) wait_frame(PER + 10);
`ifdef SERVO_PWM_FAILSAFE_EN
        chk("failsafe_set", failsafe, 1);
`endif
        step(10); upd(10'd200);
        chk("failsafe_clear", failsafe, 0);
        push(200, 1188, 0, 1);
        wait_frame(PER + 10);
        // reset mid-pulse
        step(50);
        push(512, 1500, 0, 0);
        rst = 1'b1;
        step(1);
        chk("midrst_pwm", pwm, 0);
        chk("midrst_frame_start", frame_start, 0);
        chk("midrst_active_val", active_val, 512);
        chk("midrst_failsafe", failsafe, 0);
        rst = 1'b0;
        wait_frame(10);
        step(1600);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
